misao_mem_arb: RTL and testbench
================================

MISAO_MEM_ARB -- requirements
Module: misao_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the memory address width.
REQ-002 SHALL have parameter NIB_MAX, default 4, meaning the maximum nibbles per transfer (LK16 width).
REQ-003 SHALL have port clk  input  1  system clock; one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports r0_valid / r1_valid  input  1  request valid (r0 = core, r1 = aux loader).
REQ-006 SHALL have ports r0_ready / r1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports rN_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports rN_addr  input  16  start nibble address.
REQ-009 SHALL have ports rN_len  input  2  transfer length: 00 = 1 nibble, 01 = 2, 10 = 4, 11 = reserved (treated as 1).
REQ-010 SHALL have ports rN_wdata  input  16  write data; nibble k is wdata[4k+3:4k].
REQ-011 SHALL have ports rN_rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports rN_rdata  output  16  read data; unused upper nibbles are 0.
REQ-013 SHALL have port mem_addr  output  16  memory address.
REQ-014 SHALL have port mem_en  output  1  memory access strobe.
REQ-015 SHALL have port mem_rw  output  1  1 = read, 0 = write.
REQ-016 SHALL have port mem_data_out  output  4  write nibble.
REQ-017 SHALL have port mem_data_in  input  4  read nibble, valid one cycle after its address.

Function
REQ-018 SHALL implement FSM states IDLE, XFER, WAIT, RESP.
REQ-019 In IDLE, rN_ready SHALL be combinationally high only for the granted requester; all other cycles it SHALL be 0.
REQ-020 Grant arbitration SHALL follow these rules:
- Only one valid: that requester is granted.
- Both valid: the requester not granted last time is granted (round-robin; last-grant resets to r1, so r0 wins first).
REQ-021 Acceptance (valid & ready, cycle N) SHALL latch we, addr, len and wdata, then move to XFER; requesters SHALL hold payload stable until accepted.
REQ-022 XFER SHALL issue beats k = 0..L-1 in cycles N+1..N+L:
- mem_en = 1.
- mem_addr = addr + k, modulo 2^16 (0xFFFF wraps to 0x0000).
- Nibble order is little-endian.
REQ-023 Write beats SHALL drive mem_rw = 0 and mem_data_out = wdata nibble k; after the last beat the FSM SHALL go to RESP, with rsp_valid at cycle N+L+1.
REQ-024 Read beats SHALL drive mem_rw = 1 and SHALL capture mem_data_in into rdata nibble k one cycle after beat k; after the last beat the FSM SHALL go to WAIT (last capture), then RESP, with rsp_valid at cycle N+L+2.
REQ-025 In RESP, rsp_valid SHALL pulse for exactly one cycle, only to the owning requester, with rdata stable until the next response to that requester; the FSM SHALL then return to IDLE.
REQ-026 Responses SHALL have no backpressure; a requester SHALL be able to re-request in the cycle after rsp_valid.
REQ-027 Outside XFER, mem_en SHALL be 0, mem_rw SHALL be 1 and mem_data_out SHALL be 0; no tri-state outputs are permitted.
REQ-028 Only one transfer SHALL be outstanding at a time, and a request arriving during a transfer SHALL wait in IDLE arbitration.
REQ-029 Reserved len 11 SHALL behave exactly as len 00.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL reset as follows:
- FSM goes to IDLE and last-grant goes to r1.
- Beat counter and latched request clear to 0.
- r0/r1_ready = 0, rsp_valid = 0, rdata = 0, mem_en = 0, mem_rw = 1, mem_addr = 0, mem_data_out = 0.
REQ-031 A reset during XFER, WAIT or RESP SHALL abort the transfer with no rsp_valid issued, and SHALL stop memory access starting the cycle after the reset edge.

Structure
REQ-032 Package misao_pkg SHALL hold the len encoding constants, the FSM state enum, and a function mapping len to nibble count.
REQ-033 Sub-module misao_rr_arb SHALL implement the 2-way round-robin grant, with inputs clk, rst, req[1:0], advance and output gnt[1:0] (one-hot or zero).

Verification
REQ-034 r0 read, addr 0x1234, len 10, memory nibbles 1,2,3,4 -> mem_addr sequence 0x1234..0x1237, r0_rsp_valid at N+6, r0_rdata = 0x4321.
REQ-035 r1 write, addr 0x0010, len 01, wdata 0x00A5 -> beats at 0x0010 (data 5) and 0x0011 (data A) with mem_rw = 0, r1_rsp_valid at N+3.
REQ-036 r0 and r1 both valid for three consecutive transfers after reset -> grant order r0, r1, r0.
REQ-037 Read, addr 0xFFFE, len 10 -> mem_addr sequence FFFE, FFFF, 0000, 0001.
REQ-038 rst asserted on the second beat of a 4-nibble write -> mem_en = 0 the next cycle, no rsp_valid, and the next request is accepted normally.
REQ-039 len 11 read at 0x0020 -> single beat, rsp_valid at N+3, upper 12 bits of rdata = 0.

Source files
------------

// File: rtl/misao_mem_arb_pkg.sv
// Shared types for the nibble memory arbiter: length encoding, FSM states,
// and the length-to-beat-count mapping.
package misao_pkg;

  localparam logic [1:0] LEN_1   = 2'b00;
  localparam logic [1:0] LEN_2   = 2'b01;
  localparam logic [1:0] LEN_4   = 2'b10;
  localparam logic [1:0] LEN_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT,
    RESP
  } state_e;

  // Reserved encoding is treated as a single-nibble transfer.
  function automatic logic [2:0] nib_count(input logic [1:0] len);
    case (len)
      LEN_2:         return 3'd2;
      LEN_4:         return 3'd4;
      LEN_1, LEN_RSV: return 3'd1;
      default:       return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/misao_mem_arb_if.sv
// Requester handshake bundle and nibble-wide memory bus.
interface misao_req_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        len;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, len, wdata,
                  input  ready, rsp_valid, rdata);
  modport slave  (input  valid, we, addr, len, wdata,
                  output ready, rsp_valid, rdata);
endinterface

interface misao_mem_if #(
  parameter int ADDR_W = 16
);
  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        data_out;
  logic [3:0]        data_in;

  modport master (output en, rw, addr, data_out, input data_in);
  modport slave  (input en, rw, addr, data_out, output data_in);
endinterface

// File: rtl/misao_mem_arb_rr_arb.sv
// Two-way round-robin grant; last-grant starts at r1 so r0 wins the first tie.
module misao_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q, last_d;  // 1 = r1 was granted last

  // Grant decode: a tie goes to whoever was not served last.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    else              gnt = req;
  end

  // Remember the winner only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance && (gnt != '0)) last_d = gnt[1];
  end

  // Last-grant register.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/misao_mem_arb.sv
// Two-requester arbiter onto a nibble-wide memory; one transfer in flight,
// beats issued little-endian, reads captured one cycle after each address.
module misao_mem_arb
  import misao_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NIB_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  misao_req_if.slave  r0,
  misao_req_if.slave  r1,
  misao_mem_if.master mem
);

  localparam int DATA_W = 4 * NIB_MAX;

  state_e              state_q, state_d;
  logic [1:0]          req, gnt;
  logic                accept;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          len_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          beat_q;
  logic                pend_q;
  logic [1:0]          pidx_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                last_beat;
  logic                in_xfer;

  assign req       = {r1.valid, r0.valid};
  assign in_xfer   = (state_q == XFER);
  assign last_beat = ({1'b0, beat_q} == (nib_count(len_q) - 3'd1));
  assign accept    = (state_q == IDLE) && (gnt != '0) && !rst;

  misao_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = XFER;
      XFER:    if (last_beat) state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request, beat counter and read assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      pidx_q   <= '0;
      rbuf_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt[1];
        we_q    <= gnt[1] ? r1.we    : r0.we;
        addr_q  <= gnt[1] ? r1.addr  : r0.addr;
        len_q   <= gnt[1] ? r1.len   : r0.len;
        wdata_q <= gnt[1] ? r1.wdata : r0.wdata;
        beat_q  <= '0;
        rbuf_q  <= '0;
      end else if (in_xfer) begin
        beat_q <= beat_q + 2'd1;
      end
      // A read beat's data returns one cycle later; remember which nibble.
      pend_q <= in_xfer && !we_q;
      pidx_q <= beat_q;
      if (pend_q) rbuf_q[{pidx_q, 2'b00} +: 4] <= mem.data_in;
      if (state_q == RESP) begin
        if (owner_q) rdata1_q <= rbuf_q;
        else         rdata0_q <= rbuf_q;
      end
    end
  end

  // Memory bus and requester outputs; rdata is bypassed during RESP so the
  // completed data is visible alongside the pulse.
  always_comb begin
    mem.en       = in_xfer;
    mem.rw       = !(in_xfer && we_q);
    mem.addr     = in_xfer ? addr_q + ADDR_W'(beat_q) : '0;
    mem.data_out = (in_xfer && we_q) ? wdata_q[{beat_q, 2'b00} +: 4] : '0;

    r0.ready     = (state_q == IDLE) && gnt[0] && !rst;
    r1.ready     = (state_q == IDLE) && gnt[1] && !rst;
    r0.rsp_valid = (state_q == RESP) && !owner_q;
    r1.rsp_valid = (state_q == RESP) &&  owner_q;
    r0.rdata     = ((state_q == RESP) && !owner_q) ? rbuf_q : rdata0_q;
    r1.rdata     = ((state_q == RESP) &&  owner_q) ? rbuf_q : rdata1_q;
  end

endmodule

// File: tb/tb_misao_mem_arb.sv
// Bench for misao_mem_arb: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_misao_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  misao_req_if rq0 ();
  misao_req_if rq1 ();
  misao_mem_if mbus ();

  misao_mem_arb #(.ADDR_W(16), .NIB_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .r0  (rq0),
    .r1  (rq1),
    .mem (mbus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0]  mem_arr [0:65535];  // memory seen by the DUT
  logic [3:0]  mdl_mem [0:65535];  // model's own view of memory
  logic [20:0] beat_log [$];        // {rw, data_out, addr} of every beat

  initial mbus.data_in = 4'h0;

  // Memory: read data returns one cycle after its address.
  always @(posedge clk) begin
    if (mbus.en && mbus.rw)  mbus.data_in <= mem_arr[mbus.addr];
    if (mbus.en && !mbus.rw) mem_arr[mbus.addr] <= mbus.data_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int len2n(input logic [1:0] l);
    case (l)
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  // Transaction model state.
  bit          started = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_n, m_len;
  bit          m_own, m_we;
  logic [15:0] m_addr, m_wdata, m_rd;
  bit          m_last = 1'b1;
  logic [15:0] exp_rd [2] = '{16'h0, 16'h0};
  bit          exp_ok [2] = '{1'b1, 1'b1};

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin : cmp
    logic        e_en, e_rw;
    logic [15:0] e_addr;
    logic [3:0]  e_dout;
    logic [1:0]  e_rdy, e_rsp;
    int          t, rsp_t, g;
    if (started) begin
      e_en = 1'b0; e_rw = 1'b1; e_addr = '0; e_dout = '0;
      e_rdy = '0; e_rsp = '0; t = 0; rsp_t = 0; g = -1;
      if (mbus.en) beat_log.push_back({mbus.rw, mbus.data_out, mbus.addr});
      if (m_busy) begin
        t     = cyc - m_n;
        rsp_t = m_we ? m_len + 1 : m_len + 2;
        if (t >= 1 && t <= m_len) begin
          e_en   = 1'b1;
          e_rw   = !m_we;
          e_addr = m_addr + 16'(t - 1);
          if (m_we) begin
            e_dout = m_wdata[4*(t-1) +: 4];
            mdl_mem[e_addr] = e_dout;
          end
        end
        if (t == rsp_t) begin
          e_rsp[m_own]  = 1'b1;
          exp_ok[m_own] = !m_we;
          exp_rd[m_own] = m_rd;
        end
      end else if (!rst) begin
        if (rq0.valid && rq1.valid) g = m_last ? 0 : 1;
        else if (rq0.valid)         g = 0;
        else if (rq1.valid)         g = 1;
        if (g >= 0) e_rdy[g] = 1'b1;
      end

      chk("r0_ready",     32'(rq0.ready),     32'(e_rdy[0]));
      chk("r1_ready",     32'(rq1.ready),     32'(e_rdy[1]));
      chk("r0_rsp_valid", 32'(rq0.rsp_valid), 32'(e_rsp[0]));
      chk("r1_rsp_valid", 32'(rq1.rsp_valid), 32'(e_rsp[1]));
      chk("mem_en",       32'(mbus.en),       32'(e_en));
      chk("mem_rw",       32'(mbus.rw),       32'(e_rw));
      chk("mem_addr",     32'(mbus.addr),     32'(e_addr));
      chk("mem_data_out", 32'(mbus.data_out), 32'(e_dout));
      if (exp_ok[0]) chk("r0_rdata", 32'(rq0.rdata), 32'(exp_rd[0]));
      if (exp_ok[1]) chk("r1_rdata", 32'(rq1.rdata), 32'(exp_rd[1]));

      if (rst) begin
        m_busy = 1'b0;
        m_last = 1'b1;
        exp_rd = '{16'h0, 16'h0};
        exp_ok = '{1'b1, 1'b1};
      end else if (m_busy) begin
        if (t == rsp_t) m_busy = 1'b0;
      end else if (g >= 0) begin
        m_busy  = 1'b1;
        m_n     = cyc;
        m_own   = g[0];
        m_last  = g[0];
        m_we    = (g == 0) ? rq0.we    : rq1.we;
        m_addr  = (g == 0) ? rq0.addr  : rq1.addr;
        m_len   = len2n((g == 0) ? rq0.len : rq1.len);
        m_wdata = (g == 0) ? rq0.wdata : rq1.wdata;
        m_rd    = '0;
        for (int k = 0; k < m_len; k++) m_rd[4*k +: 4] = mdl_mem[m_addr + 16'(k)];
      end
    end
  end

  task automatic set_mem(input logic [15:0] a, input logic [3:0] d);
    mem_arr[a] = d;
    mdl_mem[a] = d;
  endtask

  task automatic drive(input int who, input bit v, input bit we, input logic [15:0] addr,
                       input logic [1:0] len, input logic [15:0] wd);
    if (who == 0) begin
      rq0.valid = v; rq0.we = we; rq0.addr = addr; rq0.len = len; rq0.wdata = wd;
    end else begin
      rq1.valid = v; rq1.we = we; rq1.addr = addr; rq1.len = len; rq1.wdata = wd;
    end
  endtask

  // One complete transfer: returns accept cycle, response cycle and rdata.
  task automatic do_req(input int who, input bit we, input logic [15:0] addr,
                        input logic [1:0] len, input logic [15:0] wd,
                        output int n_acc, output int n_rsp, output logic [15:0] rd);
    bit got;
    n_acc = -1; n_rsp = -1; rd = '0;
    @(posedge clk); #1;
    drive(who, 1'b1, we, addr, len, wd);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((who == 0) ? rq0.ready : rq1.ready) begin got = 1'b1; n_acc = cyc; end
    end
    chk($sformatf("r%0d accepted", who), 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(who, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((who == 0) ? rq0.rsp_valid : rq1.rsp_valid) begin
        got = 1'b1; n_rsp = cyc; rd = (who == 0) ? rq0.rdata : rq1.rdata;
      end
    end
    chk($sformatf("r%0d responded", who), 32'(got), 32'd1);
  endtask

  task automatic chk_beat(input string name, input int idx, input logic [20:0] exp);
    chk($sformatf("%s count", name), 32'(beat_log.size() > idx), 32'd1);
    if (beat_log.size() > idx) chk(name, 32'(beat_log[idx]), 32'(exp));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin : main
    int na, nr, na0a, na0b, na1, nr0a, nr0b, nr1;
    logic [15:0] rd, rd0a, rd0b, rd1;
    bit got;

    drive(0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    for (int i = 0; i < 65536; i++) begin mem_arr[i] = 4'h0; mdl_mem[i] = 4'h0; end
    set_mem(16'h1234, 4'h1); set_mem(16'h1235, 4'h2);
    set_mem(16'h1236, 4'h3); set_mem(16'h1237, 4'h4);
    set_mem(16'hFFFE, 4'hC); set_mem(16'hFFFF, 4'hD);
    set_mem(16'h0000, 4'hE); set_mem(16'h0001, 4'hF);
    set_mem(16'h0020, 4'h7); set_mem(16'h0021, 4'h8);

    // Reset state.
    rst = 1'b1;
    @(posedge clk); #1 started = 1'b1;
    @(negedge clk);
    chk("reset mem_en",   32'(mbus.en),   32'd0);
    chk("reset mem_rw",   32'(mbus.rw),   32'd1);
    chk("reset r0_rdata", 32'(rq0.rdata), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // r0 read of four nibbles.
    beat_log.delete();
    do_req(0, 1'b0, 16'h1234, 2'b10, 16'h0, na, nr, rd);
    chk("rd4 latency", 32'(nr - na), 32'd6);
    chk("rd4 rdata",   32'(rd),      32'h4321);
    for (int k = 0; k < 4; k++)
      chk_beat($sformatf("rd4 beat%0d", k), k, {1'b1, 4'h0, 16'h1234 + 16'(k)});

    // r1 write of two nibbles.
    beat_log.delete();
    do_req(1, 1'b1, 16'h0010, 2'b01, 16'h00A5, na, nr, rd);
    chk("wr2 latency", 32'(nr - na), 32'd3);
    chk_beat("wr2 beat0", 0, {1'b0, 4'h5, 16'h0010});
    chk_beat("wr2 beat1", 1, {1'b0, 4'hA, 16'h0011});
    chk("wr2 beat total", 32'(beat_log.size()), 32'd2);
    chk("wr2 mem[0x10]", 32'(mem_arr[16'h0010]), 32'h5);

    // Address wrap past 0xFFFF.
    beat_log.delete();
    do_req(0, 1'b0, 16'hFFFE, 2'b10, 16'h0, na, nr, rd);
    chk_beat("wrap beat0", 0, {1'b1, 4'h0, 16'hFFFE});
    chk_beat("wrap beat1", 1, {1'b1, 4'h0, 16'hFFFF});
    chk_beat("wrap beat2", 2, {1'b1, 4'h0, 16'h0000});
    chk_beat("wrap beat3", 3, {1'b1, 4'h0, 16'h0001});
    chk("wrap rdata", 32'(rd), 32'hFEDC);

    // Reserved length behaves as one nibble.
    beat_log.delete();
    do_req(1, 1'b0, 16'h0020, 2'b11, 16'h0, na, nr, rd);
    chk("len11 latency", 32'(nr - na), 32'd3);
    chk("len11 beats",   32'(beat_log.size()), 32'd1);
    chk("len11 rdata",   32'(rd), 32'h0007);

    // Round-robin after reset with both requesters contending.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fork
      begin
        do_req(0, 1'b0, 16'h1234, 2'b00, 16'h0, na0a, nr0a, rd0a);
        do_req(0, 1'b0, 16'h1235, 2'b00, 16'h0, na0b, nr0b, rd0b);
      end
      do_req(1, 1'b0, 16'h1236, 2'b00, 16'h0, na1, nr1, rd1);
    join
    chk("rr first is r0",  32'(na0a < na1), 32'd1);
    chk("rr second is r1", 32'(na1 < na0b), 32'd1);
    chk("rr r1 right after r0 rsp", 32'(na1), 32'(nr0a + 1));
    chk("rr r1 rdata", 32'(rd1), 32'h0003);

    // Reset on the second beat of a four-nibble write.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 16'h0100, 2'b10, 16'h9876);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rq0.ready) got = 1'b1;
    end
    chk("abort accepted", 32'(got), 32'd1);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort beat1 en",   32'(mbus.en),       32'd1);
    chk("abort beat1 addr", 32'(mbus.addr),     32'h0101);
    chk("abort beat1 data", 32'(mbus.data_out), 32'h7);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort en after reset", 32'(mbus.en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("abort no rsp", 32'(rq0.rsp_valid), 32'd0);
      @(negedge clk);
    end
    do_req(0, 1'b0, 16'h0100, 2'b10, 16'h0, na, nr, rd);
    chk("post-abort latency", 32'(nr - na), 32'd6);
    chk("post-abort rdata",   32'(rd),      32'h0076);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
